// File: rtl/synth_write_arbiter_if.sv
// Bundle of the host (Avalon-MM), sequencer (valid/ready) and synth_avalon write-bus signals
// shared by synth_write_arbiter and whatever sits around it.
interface synth_write_arbiter_if;
    logic [5:0] host_address;
    logic [7:0] host_writedata;
    logic       host_write;
    logic       host_chipselect;
    logic       host_waitrequest;

    logic       seq_valid;
    logic       seq_ready;
    logic [5:0] seq_address;
    logic [7:0] seq_data;
    logic       seq_last;

    logic [5:0] avm_address;
    logic [7:0] avm_writedata;
    logic       avm_write;
    logic       avm_chipselect;

    logic [7:0] drop_count;
    logic       lock_abort;
    logic       busy;

    // Arbiter side
    modport slave (
        input  host_address, host_writedata, host_write, host_chipselect,
        output host_waitrequest,
        input  seq_valid, seq_address, seq_data, seq_last,
        output seq_ready,
        output avm_address, avm_writedata, avm_write, avm_chipselect,
        output drop_count, lock_abort, busy
    );

    // Requester / register-file side
    modport master (
        output host_address, host_writedata, host_write, host_chipselect,
        input  host_waitrequest,
        output seq_valid, seq_address, seq_data, seq_last,
        input  seq_ready,
        input  avm_address, avm_writedata, avm_write, avm_chipselect,
        input  drop_count, lock_abort, busy
    );
endinterface

// File: rtl/synth_write_arbiter.sv
// Round-robin arbiter sharing the synth register-file write port between the host CPU and the
// note sequencer; sequencer bursts hold an atomic lock that is aborted after an idle timeout.
module synth_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned NUM_REGS     = 36,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                 clk_50mhz,
    input  logic                 reset_n,
    synth_write_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [6:0]  NUM_REGS_W = 7'(NUM_REGS);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
        logic       last;
    } entry_t;

    typedef enum logic {StRr, StSeqLock} state_e;

    entry_t      host_mem [FIFO_DEPTH];
    entry_t      seq_mem  [FIFO_DEPTH];
    logic [AW:0] host_wp_q, host_rp_q, seq_wp_q, seq_rp_q;

    logic host_empty, host_full, seq_empty, seq_full;
    logic host_push, seq_push;
    logic grant_host, grant_seq, pop, in_range;
    entry_t pop_entry;

    state_e     state_q;
    logic       rr_last_seq_q;
    logic [7:0] idle_cnt_q;
    logic [5:0] avm_address_q;
    logic [7:0] avm_writedata_q;
    logic       avm_write_q;
    logic [7:0] drop_count_q;
    logic       lock_abort_q;

    assign host_empty = (host_wp_q == host_rp_q);
    assign host_full  = (host_wp_q[AW] != host_rp_q[AW]) &&
                        (host_wp_q[AW-1:0] == host_rp_q[AW-1:0]);
    assign seq_empty  = (seq_wp_q == seq_rp_q);
    assign seq_full   = (seq_wp_q[AW] != seq_rp_q[AW]) &&
                        (seq_wp_q[AW-1:0] == seq_rp_q[AW-1:0]);

    // Full flags alone gate pushes; a same-cycle pop never frees a slot early.
    assign host_push = bus.host_write & bus.host_chipselect & ~host_full;
    assign seq_push  = bus.seq_valid & ~seq_full;

    always_comb begin
        grant_host = 1'b0;
        grant_seq  = 1'b0;
        unique case (state_q)
            StRr: begin
                if (!host_empty && (seq_empty || rr_last_seq_q)) grant_host = 1'b1;
                else if (!seq_empty)                             grant_seq  = 1'b1;
            end
            StSeqLock: grant_seq = ~seq_empty;
            default: ;
        endcase
    end

    always_comb begin
        pop_entry = seq_mem[seq_rp_q[AW-1:0]];
        if (grant_host) pop_entry = host_mem[host_rp_q[AW-1:0]];
    end

    assign pop      = grant_host | grant_seq;
    assign in_range = ({1'b0, pop_entry.addr} < NUM_REGS_W);

    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            host_wp_q <= '0;
            host_rp_q <= '0;
            seq_wp_q  <= '0;
            seq_rp_q  <= '0;
        end else begin
            if (host_push) begin
                host_mem[host_wp_q[AW-1:0]] <= '{addr: bus.host_address,
                                                 data: bus.host_writedata, last: 1'b1};
                host_wp_q <= host_wp_q + PTR_ONE;
            end
            if (seq_push) begin
                seq_mem[seq_wp_q[AW-1:0]] <= '{addr: bus.seq_address,
                                               data: bus.seq_data, last: bus.seq_last};
                seq_wp_q <= seq_wp_q + PTR_ONE;
            end
            if (grant_host) host_rp_q <= host_rp_q + PTR_ONE;
            if (grant_seq)  seq_rp_q  <= seq_rp_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            state_q         <= StRr;
            rr_last_seq_q   <= 1'b1;
            idle_cnt_q      <= '0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            drop_count_q    <= '0;
            lock_abort_q    <= 1'b0;
        end else begin
            avm_write_q  <= 1'b0;
            lock_abort_q <= 1'b0;
            if (pop) begin
                rr_last_seq_q <= grant_seq;
                if (in_range) begin
                    avm_write_q     <= 1'b1;
                    avm_address_q   <= pop_entry.addr;
                    avm_writedata_q <= pop_entry.data;
                end else if (drop_count_q != 8'hff) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
            unique case (state_q)
                StRr: begin
                    if (grant_seq && !pop_entry.last) begin
                        state_q    <= StSeqLock;
                        idle_cnt_q <= '0;
                    end
                end
                StSeqLock: begin
                    // Dropped entries still count as pops for lock purposes.
                    if (grant_seq) begin
                        idle_cnt_q <= '0;
                        if (pop_entry.last) state_q <= StRr;
                    end else if (idle_cnt_q == TIMEOUT_LAST) begin
                        state_q      <= StRr;
                        lock_abort_q <= 1'b1;
                        idle_cnt_q   <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StRr;
            endcase
        end
    end

    assign bus.host_waitrequest = host_full;
    assign bus.seq_ready        = ~seq_full;
    assign bus.avm_address      = avm_address_q;
    assign bus.avm_writedata    = avm_writedata_q;
    assign bus.avm_write        = avm_write_q;
    assign bus.avm_chipselect   = avm_write_q;
    assign bus.drop_count       = drop_count_q;
    assign bus.lock_abort       = lock_abort_q;
    assign bus.busy             = ~host_empty | ~seq_empty | (state_q == StSeqLock);
endmodule

// File: doc/synth_write_arbiter.md
# synth_write_arbiter

Shares the synth register-file write port between two requesters: the host CPU (Avalon-MM slave side) and a hardware note sequencer (valid/ready stream). It sits directly in front of `synth_avalon` and drives its 6-bit address / 8-bit data write bus. Each requester has its own small FIFO. Arbitration is round-robin. Sequencer bursts are atomic, so that all registers of one voice update together.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries per requester FIFO (power of two, ≥2)
- NUM_REGS, 36, valid register addresses are 0..NUM_REGS-1
- LOCK_TIMEOUT, 255, idle cycles before a stalled sequencer lock is aborted (1..255)

Ports:
- clk_50mhz  in  1  system clock
- reset_n  in  1  synchronous, active-low reset (sampled on clk_50mhz)
- host_address  in  6  host register address
- host_writedata  in  8  host write data
- host_write  in  1  host write strobe
- host_chipselect  in  1  host select
- host_waitrequest  out  1  high when the host FIFO is full
- seq_valid  in  1  sequencer entry valid
- seq_ready  out  1  high when the sequencer FIFO is not full
- seq_address  in  6  sequencer register address
- seq_data  in  8  sequencer write data
- seq_last  in  1  marks the final entry of an atomic burst
- avm_address  out  6  to synth_avalon avs_address
- avm_writedata  out  8  to synth_avalon avs_writedata
- avm_write  out  1  single-cycle write pulse
- avm_chipselect  out  1  equal to avm_write
- drop_count  out  8  saturating count of out-of-range entries
- lock_abort  out  1  one-cycle pulse when a lock times out
- busy  out  1  either FIFO non-empty or a lock is held

## Operation
- **Host push:** occurs when host_write & host_chipselect & !host_waitrequest. The entry is stored as {addr, data, last=1}.
- **Sequencer push:** occurs when seq_valid & seq_ready. The entry is stored as {addr, data, seq_last}.
- **Full flags:** host_waitrequest and seq_ready depend only on the full flags. There is no push on a full FIFO, even if a pop happens in the same cycle.
- **Pop:** at most one entry is popped per cycle, from the granted FIFO's head.
- **Arbiter states:**
  - RR (unlocked): if only one head is valid, grant it. If both are valid, grant the requester not granted last; rr_last is updated on every pop.
  - SEQ_LOCK: entered when a sequencer entry with last=0 is popped. Only the sequencer FIFO is served. The state returns to RR when an entry with last=1 is popped.
- **Lock timeout:** in SEQ_LOCK, an idle counter increments on each cycle the sequencer FIFO is empty and clears on each sequencer pop. When it reaches LOCK_TIMEOUT, the state returns to RR, lock_abort pulses for 1 cycle, and the counter clears.
- **Out-of-range entries:** a popped entry with addr ≥ NUM_REGS is discarded. No avm_write is issued, and drop_count increments, saturating at 255. The entry's last bit still governs the lock.
- **Issued writes:** avm_write/avm_chipselect pulse high for 1 cycle per valid pop. avm_address/avm_writedata hold their last value otherwise.
- **Slave handshake:** the slave has no waitrequest, so every pulse is accepted.

## Timing
- **Reset values:**
  - avm_* = 0, drop_count = 0, lock_abort = 0, busy = 0.
  - host_waitrequest = 0, seq_ready = 1.
  - FIFOs empty, state RR, rr_last = sequencer (the host wins the first tie), idle counter 0.
- **Latency:** an entry pushed at edge E is at the FIFO head after E and can be popped at E+1. The registered avm_* outputs are therefore high in the cycle after E+1, i.e. 2 cycles push→write when uncontended.
- **Throughput:** 1 write per cycle sustained.
- **Full-flag update:** host_waitrequest/seq_ready update the cycle after the push that fills the FIFO.
- **Reset mid-burst:** FIFO contents are discarded and the lock is cleared. No partial write is issued after reset deasserts.
- **Simultaneous timeout and push:** if a push lands in the cycle the idle counter reaches LOCK_TIMEOUT, the abort still happens. The pushed entry is then served under RR.

## Test plan
- **Single host write:** host writes addr 5, data 0xA3 → avm_write pulses once with 5/0xA3, 2 cycles after acceptance. drop_count stays 0.
- **Host FIFO fill:** 5 back-to-back host writes while sequencer traffic keeps the grant busy → host_waitrequest is high after the 4th. All 5 eventually appear in order with no loss.
- **Contention:** both FIFOs hold 3 entries (all last=1) → the output alternates host, seq, host, seq, host, seq.
- **Atomic burst:** sequencer burst addrs 0,1,2 (last on 2) with host entries pending → the three sequencer writes issue consecutively before any host write.
- **Lock timeout:** sequencer sends addr 9 with last=0, then idles with LOCK_TIMEOUT=8 → lock_abort pulses 8 cycles after the pop, and a pending host write is then issued.
- **Out-of-range addresses:** host writes addr 36 and 63 → no avm_write, drop_count = 2. Then 254 more → drop_count holds at 255.
